// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780-class responder: decodes E/RS/RW bus transfers and holds a 128-byte DDRAM.
// It also keeps the address counter and busy flag, and answers status and data reads.
module lcd_hd44780_responder #(
   parameter int CLEAR_CYCLES = 82000,
   parameter int CMD_CYCLES   = 2000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   inout  wire  [7:0] LCD_data,
   output logic       busy,
   output logic [6:0] ac,
   output logic [2:0] disp_ctl,
   output logic       overrun,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_data
);

   localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] FILL_REST  = CNT_W'(CLEAR_CYCLES - 128);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLR_FILL} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [6:0]       fill_reg, fill_next;
   logic             fill_we;

   logic             e_q_reg, rs_reg, rw_reg;
   logic [7:0]       data_reg;
   logic [6:0]       ac_reg;
   logic             id_reg, shift_reg;
   logic [2:0]       disp_ctl_reg;
   logic             overrun_reg;

   logic [7:0]       ddram [128];
   logic [7:0]       rd_q;

   logic             commit, accept, data_we;
   logic             instr_clear, instr_home, instr_nop;
   logic [6:0]       ac_inc, ac_dec, ac_step;

   assign commit  = e_q_reg & ~LCD_E;
   assign accept  = commit & ~rw_reg & (state_reg == ST_IDLE);
   assign data_we = accept & rs_reg;

   assign instr_clear = ~rs_reg & (data_reg == 8'h01);
   assign instr_home  = ~rs_reg & (data_reg[7:1] == 7'b0000001);
   assign instr_nop   = ~rs_reg & (data_reg == 8'h00);

   assign ac_inc  = ac_reg + 7'd1;
   assign ac_dec  = ac_reg - 7'd1;
   assign ac_step = id_reg ? ac_inc : ac_dec;

   assign busy     = (state_reg != ST_IDLE);
   assign ac       = ac_reg;
   assign disp_ctl = disp_ctl_reg;
   assign overrun  = overrun_reg;

   // Read data is driven straight from the live RS/RW/E pins so the host sees it within the pulse.
   assign LCD_data = (LCD_E && LCD_RW && reset_n) ? (LCD_RS ? rd_q : {busy, ac_reg}) : 8'hzz;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_CLR_FILL;
         count_reg <= '0;
         fill_reg  <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         fill_reg  <= fill_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      fill_next  = fill_reg;
      fill_we    = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (accept && !instr_nop) begin
               if (instr_clear) begin
                  state_next = ST_CLR_FILL;
                  fill_next  = '0;
               end else begin
                  state_next = ST_BUSY;
                  count_next = instr_home ? CLEAR_LOAD : CMD_LOAD;
               end
            end
         end
         ST_CLR_FILL: begin
            fill_we   = 1'b1;
            fill_next = fill_reg + 7'd1;
            // Fill time is part of the clear busy period, so only the remainder is counted.
            if (fill_reg == 7'd127) begin
               state_next = ST_BUSY;
               count_next = FILL_REST;
            end
         end
         ST_BUSY: begin
            count_next = count_reg - CNT_W'(1);
            if (count_reg <= CNT_W'(1)) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         e_q_reg      <= 1'b0;
         rs_reg       <= 1'b0;
         rw_reg       <= 1'b0;
         data_reg     <= 8'h00;
         ac_reg       <= 7'd0;
         id_reg       <= 1'b1;
         shift_reg    <= 1'b0;
         disp_ctl_reg <= 3'd0;
         overrun_reg  <= 1'b0;
      end else begin
         e_q_reg <= LCD_E;
         if (LCD_E) begin
            rs_reg   <= LCD_RS;
            rw_reg   <= LCD_RW;
            data_reg <= LCD_data;
         end
         if (commit) begin
            if (rw_reg) begin
               if (rs_reg) ac_reg <= ac_step;
            end else if (state_reg != ST_IDLE) begin
               overrun_reg <= 1'b1;
            end else if (rs_reg) begin
               ac_reg <= ac_step;
            end else begin
               casez (data_reg)
                  8'b1???????: ac_reg <= data_reg[6:0];
                  8'b01??????: ;
                  8'b001?????: ;
                  8'b0001????: if (!data_reg[3]) ac_reg <= data_reg[2] ? ac_inc : ac_dec;
                  8'b00001???: disp_ctl_reg <= data_reg[2:0];
                  8'b000001??: begin
                     id_reg    <= data_reg[1];
                     shift_reg <= data_reg[0];
                  end
                  8'b0000001?: ac_reg <= 7'd0;
                  8'b00000001: begin
                     ac_reg <= 7'd0;
                     id_reg <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) ddram[fill_reg] <= 8'h20;
      else if (data_we) ddram[ac_reg] <= data_reg;
      rd_q <= ddram[ac_reg];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) dbg_data <= 8'h00;
      else dbg_data <= ddram[dbg_addr];
   end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: randomized bus transfers checked against a
// behavioural model of DDRAM, address counter, entry mode, display control and busy durations.
module tb_lcd_hd44780_responder;
   localparam int CLR = 300;
   localparam int CMD = 24;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] drv = 8'h00;
   logic       oe = 1'b0;
   wire  [7:0] lcd_data;
   logic       busy, overrun;
   logic [6:0] ac;
   logic [2:0] disp_ctl;
   logic [6:0] dbg_addr = 7'd0;
   logic [7:0] dbg_data;

   assign lcd_data = oe ? drv : 8'hzz;

   lcd_hd44780_responder #(.CLEAR_CYCLES(CLR), .CMD_CYCLES(CMD)) dut (
      .clk(clk), .reset_n(reset_n), .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
      .LCD_data(lcd_data), .busy(busy), .ac(ac), .disp_ctl(disp_ctl), .overrun(overrun),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int runs = 0;
   int fails = 0;

   // Behavioural model of the panel state
   logic [7:0] m_ram [128];
   int         m_ac;
   bit         m_id;
   logic [2:0] m_disp;
   bit         m_ovr;

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
      m_ac = 0; m_id = 1'b1; m_disp = 3'd0; m_ovr = 1'b0;
   endfunction

   // Applies an accepted write to the model; returns the busy time it starts.
   function automatic int model_write(input bit rs, input logic [7:0] d);
      int top;
      if (rs) begin
         m_ram[m_ac] = d;
         m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
         return CMD;
      end
      top = -1;
      for (int b = 0; b < 8; b++) if (d[b]) top = b;
      case (top)
         7: begin m_ac = int'(d[6:0]); return CMD; end
         6, 5: return CMD;
         4: begin
            if (!d[3]) m_ac = (m_ac + (d[2] ? 1 : 127)) % 128;
            return CMD;
         end
         3: begin m_disp = d[2:0]; return CMD; end
         2: begin m_id = d[1]; return CMD; end
         1: begin m_ac = 0; return CLR; end
         0: begin
            m_ac = 0; m_id = 1'b1;
            for (int i = 0; i < 128; i++) m_ram[i] = 8'h20;
            return CLR;
         end
         default: return 0;
      endcase
   endfunction

   task automatic bus_write(input bit rs, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b0; drv = d; oe = 1'b1; lcd_e = 1'b1;
      @(negedge clk);
      lcd_e = 1'b0;
      @(posedge clk);
      #1 oe = 1'b0;
      $display("[TB] t=%0t write rs=%0d data=%02h", $time, rs, d);
   endtask

   task automatic bus_read(input bit rs, output logic [7:0] v);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1; oe = 1'b0; lcd_e = 1'b1;
      @(negedge clk);
      @(negedge clk);
      v = lcd_data;
      lcd_e = 1'b0;
      @(posedge clk);
      #1 lcd_rw = 1'b0;
      $display("[TB] t=%0t read  rs=%0d data=%02h", $time, rs, v);
   endtask

   task automatic measure_busy(output int len);
      len = 0;
      for (int i = 0; i < 2 * CLR + 50; i++) begin
         @(negedge clk);
         if (!busy) return;
         len++;
      end
      len = -1;
   endtask

   task automatic dbg_peek(input logic [6:0] a, output logic [7:0] v);
      @(negedge clk);
      dbg_addr = a;
      @(negedge clk);
      v = dbg_data;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      int t0, elapsed;
      bit seen_idle;
      model_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      runs++; if (ac !== 7'd0) begin fails++; $display("FAIL reset_ac got=%0h exp=0", ac); end
      runs++; if (disp_ctl !== m_disp) begin fails++; $display("FAIL reset_disp got=%0h exp=%0h", disp_ctl, m_disp); end
      runs++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
      runs++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL reset_dbg got=%02h exp=00", dbg_data); end
      reset_n = 1'b1;
      t0 = cyc;
      @(negedge clk);
      runs++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy_first got=%0b exp=1", busy); end
      seen_idle = 1'b0;
      elapsed = 0;
      for (int i = 0; i < CLR && !seen_idle; i++) begin
         bus_read(1'b0, v);
         if (v === 8'h00) begin
            seen_idle = 1'b1;
            elapsed = cyc - t0;
         end else if (v !== 8'h80) begin
            runs++; fails++;
            $display("FAIL reset_status got=%02h exp=80", v);
         end
      end
      runs++; if (!seen_idle) begin fails++; $display("FAIL reset_status_idle got=busy exp=00 within %0d reads", CLR); end
      runs++;
      if (elapsed < CLR - 8 || elapsed > CLR + 8) begin
         fails++; $display("FAIL reset_busy_time got=%0d exp=%0d+-8", elapsed, CLR);
      end
      for (int i = 0; i < 128; i++) begin
         dbg_peek(7'(i), v);
         runs++; if (v !== m_ram[i]) begin fails++; $display("FAIL reset_fill[%0d] got=%02h exp=%02h", i, v, m_ram[i]); end
      end
   endtask

   task automatic write_checked(input string tag, input bit rs, input logic [7:0] d);
      int dur, len;
      dur = model_write(rs, d);
      bus_write(rs, d);
      measure_busy(len);
      runs++;
      if (len < dur - 1 || len > dur + 1) begin
         fails++; $display("FAIL %s_busy_len got=%0d exp=%0d+-1", tag, len, dur);
      end
   endtask

   task automatic test_hi();
      logic [7:0] v;
      write_checked("hi_setaddr", 1'b0, 8'h80 | 8'h40);
      write_checked("hi_H", 1'b1, 8'h48);
      write_checked("hi_i", 1'b1, 8'h69);
      bus_read(1'b0, v);
      runs++; if (v !== {1'b0, 7'(m_ac)}) begin fails++; $display("FAIL hi_status got=%02h exp=%02h", v, {1'b0, 7'(m_ac)}); end
      dbg_peek(7'h40, v);
      runs++; if (v !== m_ram[8'h40]) begin fails++; $display("FAIL hi_ram40 got=%02h exp=%02h", v, m_ram[8'h40]); end
      dbg_peek(7'h41, v);
      runs++; if (v !== m_ram[8'h41]) begin fails++; $display("FAIL hi_ram41 got=%02h exp=%02h", v, m_ram[8'h41]); end
   endtask

   task automatic test_dec_wrap();
      logic [7:0] v;
      write_checked("dec_entry", 1'b0, 8'h04);
      write_checked("dec_addr0", 1'b0, 8'h80);
      write_checked("dec_data", 1'b1, 8'h55);
      dbg_peek(7'h00, v);
      runs++; if (v !== m_ram[0]) begin fails++; $display("FAIL dec_ram0 got=%02h exp=%02h", v, m_ram[0]); end
      runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL dec_ac_wrap got=%0h exp=%0h", ac, m_ac); end
   endtask

   task automatic test_overrun();
      logic [7:0] v;
      int first_addr, len;
      runs++; if (overrun !== m_ovr) begin fails++; $display("FAIL ovr_initial got=%0b exp=%0b", overrun, m_ovr); end
      write_checked("ovr_entry", 1'b0, 8'h06);
      first_addr = m_ac;
      void'(model_write(1'b1, 8'hA7));
      bus_write(1'b1, 8'hA7);
      bus_read(1'b0, v);
      runs++; if (v !== {1'b1, 7'(m_ac)}) begin fails++; $display("FAIL ovr_status1 got=%02h exp=%02h", v, {1'b1, 7'(m_ac)}); end
      bus_write(1'b1, 8'h3C);
      m_ovr = 1'b1;
      @(negedge clk);
      runs++; if (overrun !== m_ovr) begin fails++; $display("FAIL ovr_flag got=%0b exp=%0b", overrun, m_ovr); end
      bus_read(1'b0, v);
      runs++; if (v !== {1'b1, 7'(m_ac)}) begin fails++; $display("FAIL ovr_status2 got=%02h exp=%02h", v, {1'b1, 7'(m_ac)}); end
      measure_busy(len);
      runs++; if (len < 0) begin fails++; $display("FAIL ovr_idle got=timeout exp=idle"); end
      dbg_peek(7'(first_addr), v);
      runs++; if (v !== m_ram[first_addr]) begin fails++; $display("FAIL ovr_ram_first got=%02h exp=%02h", v, m_ram[first_addr]); end
      dbg_peek(7'(m_ac), v);
      runs++; if (v !== m_ram[m_ac]) begin fails++; $display("FAIL ovr_ram_dropped got=%02h exp=%02h", v, m_ram[m_ac]); end
      runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL ovr_ac got=%0h exp=%0h", ac, m_ac); end
   endtask

   task automatic test_read();
      logic [7:0] v;
      write_checked("rd_addr_a", 1'b0, 8'h90);
      write_checked("rd_data", 1'b1, 8'hC3);
      write_checked("rd_addr_b", 1'b0, 8'h90);
      @(negedge clk);
      lcd_rs = 1'b1; lcd_rw = 1'b1; oe = 1'b0; lcd_e = 1'b1;
      @(negedge clk);
      @(negedge clk);
      v = lcd_data;
      $display("[TB] t=%0t read  rs=1 data=%02h", $time, v);
      runs++; if (v !== m_ram[m_ac]) begin fails++; $display("FAIL rd_bus got=%02h exp=%02h", v, m_ram[m_ac]); end
      lcd_e = 1'b0; drv = 8'h00; oe = 1'b1;
      m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
      @(negedge clk);
      v = lcd_data;
      runs++; if (v !== 8'h00) begin fails++; $display("FAIL rd_release got=%02h exp=00", v); end
      oe = 1'b0; lcd_rw = 1'b0;
      runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL rd_ac got=%0h exp=%0h", ac, m_ac); end
      runs++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_nobusy got=%0b exp=0", busy); end
   endtask

   task automatic test_random();
      logic [7:0] d, v;
      int op;
      for (int it = 0; it < 24; it++) begin
         op = $urandom_range(0, 7);
         case (op)
            0: d = 8'h80 | 8'($urandom_range(0, 127));
            1: d = 8'h04 | 8'($urandom_range(0, 3));
            2: d = 8'h10 | 8'($urandom_range(0, 15));
            3: d = 8'h08 | 8'($urandom_range(0, 7));
            4: d = 8'($urandom_range(0, 255));
            6: d = ($urandom_range(0, 1) != 0) ? (8'h40 | 8'($urandom_range(0, 63)))
                                               : (8'h20 | 8'($urandom_range(0, 31)));
            default: d = ($urandom_range(0, 1) != 0) ? (8'h02 | 8'($urandom_range(0, 1))) : 8'h00;
         endcase
         if (op == 5) begin
            bus_read(1'b1, v);
            runs++; if (v !== m_ram[m_ac]) begin fails++; $display("FAIL rnd_read[%0d] got=%02h exp=%02h", it, v, m_ram[m_ac]); end
            m_ac = (m_ac + (m_id ? 1 : 127)) % 128;
            @(negedge clk);
         end else begin
            write_checked("rnd", op == 4, d);
         end
         runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL rnd_ac[%0d] got=%0h exp=%0h", it, ac, m_ac); end
         runs++; if (disp_ctl !== m_disp) begin fails++; $display("FAIL rnd_disp[%0d] got=%0h exp=%0h", it, disp_ctl, m_disp); end
      end
      for (int i = 0; i < 128; i++) begin
         dbg_peek(7'(i), v);
         runs++; if (v !== m_ram[i]) begin fails++; $display("FAIL rnd_ram[%0d] got=%02h exp=%02h", i, v, m_ram[i]); end
      end
   endtask

   task automatic test_clear_reset();
      logic [7:0] v;
      int len;
      write_checked("clr_entry", 1'b0, 8'h04);
      write_checked("clr_d1", 1'b1, 8'h11);
      write_checked("clr_d2", 1'b1, 8'h22);
      void'(model_write(1'b0, 8'h01));
      bus_write(1'b0, 8'h01);
      repeat (40) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      measure_busy(len);
      runs++;
      if (len < CLR - 4 || len > CLR + 2) begin
         fails++; $display("FAIL clr_busy_len got=%0d exp=%0d", len, CLR);
      end
      for (int i = 0; i < 128; i++) begin
         dbg_peek(7'(i), v);
         runs++; if (v !== m_ram[i]) begin fails++; $display("FAIL clr_ram[%0d] got=%02h exp=%02h", i, v, m_ram[i]); end
      end
      runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL clr_ac got=%0h exp=%0h", ac, m_ac); end
      write_checked("clr_after", 1'b1, 8'h77);
      runs++; if (ac !== 7'(m_ac)) begin fails++; $display("FAIL clr_id_restored got=%0h exp=%0h", ac, m_ac); end
   endtask

   initial begin
      test_reset();
      test_hi();
      test_dec_wrap();
      test_overrun();
      test_read();
      test_random();
      test_clear_reset();
      $display("[TB] %0d tests run, %0d failed", runs, fails);
      $finish;
   end
endmodule
